// File: rtl/cycle_sequencer.sv
// cycle_sequencer: machine-cycle timing for the 5-bit-opcode CPU.
// Sequences each instruction FETCH -> T1 -> T2 -> T3 -> T4. It inserts wait
// states while memory is not ready, and stops on the HALT opcode or on a
// memory-wait timeout.
//
// Ports:
//   clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   Run        level; permits starting a new instruction (sampled in IDLE/S4)
//   Opcode     current opcode from IR, valid T1..T4
//   MemReq     memory access requested by control logic (sampled in T3 only)
//   MemReady   memory access completes this cycle
//   Fetch      instruction fetch cycle active
//   IRLoad     IR captures memory data at the next edge
//   T1..T4     one-hot timing strobes
//   Halted     sticky; core stopped
//   Timeout    sticky; stop was caused by a memory-wait timeout
//   InstrCount retired-instruction counter (wraps)
`timescale 1ns/1ps
module cycle_sequencer #(
  parameter int unsigned          OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 5'h1F,
  parameter int unsigned          WAIT_MAX    = 15,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReq,
  input  logic                MemReady,
  output logic                Fetch,
  output logic                IRLoad,
  output logic                T1,
  output logic                T2,
  output logic                T3,
  output logic                T4,
  output logic                Halted,
  output logic                Timeout,
  output logic [CNT_W-1:0]    InstrCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_HALT
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic. The wait counter defaults to zero, so it clears on
  // entry to FETCH/S3 and whenever they advance. It only counts while stalled.
  // Hitting WAIT_LIM while still stalled means this would be stall
  // WAIT_MAX+1, so the core halts.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (MemReady) begin
          state_d = ST_S1;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: begin
        if (!MemReq || MemReady) begin
          state_d = ST_S4;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_S4: begin
        cnt_d = cnt_q + 1'b1;
        if (Opcode == HALT_OPCODE) state_d = ST_HALT;
        else if (Run)              state_d = ST_FETCH;
        else                       state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: Moore decode of the state register. IRLoad is the only output
  // that also depends on an input.
  always_comb begin
    Fetch      = 1'b0;
    T1         = 1'b0;
    T2         = 1'b0;
    T3         = 1'b0;
    T4         = 1'b0;
    Halted     = 1'b0;
    unique case (state_q)
      ST_FETCH: Fetch  = 1'b1;
      ST_S1:    T1     = 1'b1;
      ST_S2:    T2     = 1'b1;
      ST_S3:    T3     = 1'b1;
      ST_S4:    T4     = 1'b1;
      ST_HALT:  Halted = 1'b1;
      default:  ;
    endcase
    IRLoad     = Fetch & MemReady;
    Timeout    = timeout_q;
    InstrCount = cnt_q;
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
`timescale 1ns/1ps
module tb_cycle_sequencer;

  localparam int unsigned TB_CNT_W = 8;

  // Expected output vector: {Halted, Timeout, Fetch, IRLoad, T1, T2, T3, T4}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_F    = 8'b0010_0000;
  localparam logic [7:0] V_FL   = 8'b0011_0000;
  localparam logic [7:0] V_T1   = 8'b0000_1000;
  localparam logic [7:0] V_T2   = 8'b0000_0100;
  localparam logic [7:0] V_T3   = 8'b0000_0010;
  localparam logic [7:0] V_T4   = 8'b0000_0001;
  localparam logic [7:0] V_H    = 8'b1000_0000;
  localparam logic [7:0] V_HT   = 8'b1100_0000;

  logic                clk = 1'b0;
  logic                Reset;
  logic                Run;
  logic [4:0]          Opcode;
  logic                MemReq;
  logic                MemReady;
  logic                Fetch, IRLoad, T1, T2, T3, T4, Halted, Timeout;
  logic [TB_CNT_W-1:0] InstrCount;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned exp_cnt     = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs;

  assign obs = {Halted, Timeout, Fetch, IRLoad, T1, T2, T3, T4};

  cycle_sequencer #(
    .OPCODE_W   (5),
    .HALT_OPCODE(5'h1F),
    .WAIT_MAX   (15),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Run       (Run),
    .Opcode    (Opcode),
    .MemReq    (MemReq),
    .MemReady  (MemReady),
    .Fetch     (Fetch),
    .IRLoad    (IRLoad),
    .T1        (T1),
    .T2        (T2),
    .T3        (T3),
    .T4        (T4),
    .Halted    (Halted),
    .Timeout   (Timeout),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare them
  // mid-cycle, and leave the bench at posedge+1.
  task automatic step(input logic run, input logic req, input logic rdy,
                      input logic [4:0] op, input logic [7:0] ev, input string tag);
    Run      = run;
    MemReq   = req;
    MemReady = rdy;
    Opcode   = op;
    exp_q.push_back(ev);
    @(negedge clk);
    if (exp_q.size() == 0) check({tag, "_empty"}, 32'd1, 32'd0);
    else                   check(tag, 32'(obs), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  // One complete instruction starting in FETCH. The run_tail value is
  // applied from T2 onward.
  task automatic instr(input logic [4:0] op, input int unsigned fstall,
                       input int unsigned tstall, input logic req, input logic run_tail);
    for (int unsigned i = 0; i < fstall; i++) step(1'b1, 1'b0, 1'b0, op, V_F, "fetch_wait");
    step(1'b1, 1'b0, 1'b1, op, V_FL, "fetch");
    step(1'b1, 1'b0, 1'b1, op, V_T1, "t1");
    step(run_tail, 1'b0, 1'b1, op, V_T2, "t2");
    for (int unsigned i = 0; i < tstall; i++) step(run_tail, 1'b1, 1'b0, op, V_T3, "t3_wait");
    step(run_tail, req, 1'b1, op, V_T3, "t3");
    step(run_tail, 1'b0, 1'b1, op, V_T4, "t4");
    exp_cnt++;
    check("instr_count", 32'(InstrCount), 32'(exp_cnt % (1 << TB_CNT_W)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Run = 1'b0; MemReq = 1'b0; MemReady = 1'b0; Opcode = 5'h00;
    @(posedge clk); @(posedge clk); #1;
    check("reset_vec", 32'(obs), 32'(V_IDLE));
    check("reset_cnt", 32'(InstrCount), 32'd0);
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 5'h01, V_IDLE, "idle_hold");

    // Retire one instruction, then reset asynchronously in the middle of a T3 stall.
    step(1'b1, 1'b0, 1'b1, 5'h01, V_IDLE, "idle_run");
    instr(5'h01, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'h02, V_FL, "fetch_pre_rst");
    step(1'b1, 1'b0, 1'b1, 5'h02, V_T1, "t1_pre_rst");
    step(1'b1, 1'b0, 1'b1, 5'h02, V_T2, "t2_pre_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'h02, V_T3, "t3_stall_pre_rst");
    Run = 1'b0; MemReq = 1'b0;
    Reset = 1'b1;
    #1;
    check("midstall_rst_vec", 32'(obs), 32'(V_IDLE));
    check("midstall_rst_cnt", 32'(InstrCount), 32'd0);
    Reset = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b1, 5'h01, V_IDLE, "idle_after_rst");
    step(1'b1, 1'b0, 1'b1, 5'h01, V_IDLE, "idle_run2");

    // Three back-to-back instructions with no stalls.
    for (int i = 0; i < 3; i++) instr(5'h01, 0, 0, 1'b0, 1'b1);
    check("count_three", 32'(InstrCount), 32'd3);

    // T3 stall of 4 cycles, memory request pending.
    instr(5'h0B, 0, 4, 1'b1, 1'b1);

    // Exactly WAIT_MAX fetch stalls: no timeout.
    instr(5'h01, 15, 0, 1'b0, 1'b1);

    // Counter wrap; Run is dropped in T2 of the final instruction.
    while (exp_cnt < 255) instr(5'h03, 0, 0, 1'b0, 1'b1);
    check("count_ff", 32'(InstrCount), 32'hFF);
    instr(5'h04, 0, 0, 1'b0, 1'b0);
    check("count_wrap", 32'(InstrCount), 32'd0);
    step(1'b0, 1'b0, 1'b1, 5'h04, V_IDLE, "idle_after_drop");

    // HALT opcode: halts after its T4, and Run is ignored afterwards.
    step(1'b1, 1'b0, 1'b1, 5'h1F, V_IDLE, "idle_run3");
    instr(5'h1F, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 5'h01, V_H, "halted");
    check("halt_cnt", 32'(InstrCount), 32'd1);
    Run = 1'b0;
    Reset = 1'b1;
    #1;
    check("halt_rst_vec", 32'(obs), 32'(V_IDLE));
    Reset = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;

    // WAIT_MAX+1 fetch stalls: timeout halts the core.
    step(1'b1, 1'b0, 1'b0, 5'h01, V_IDLE, "idle_run4");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 5'h01, V_F, "fetch_to_wait");
    step(1'b1, 1'b0, 1'b1, 5'h01, V_HT, "timeout_halt");
    step(1'b1, 1'b0, 1'b1, 5'h01, V_HT, "timeout_sticky");
    check("timeout_cnt", 32'(InstrCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
